// File: rtl/q2_serial_alu.sv
// q2_serial_alu: digit-serial LOAD/NOR/ADD/SHR ALU, LSB digit first, start/done handshake
module q2_serial_alu #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] x,
  input  logic             flag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_out
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] wop;
  logic [WIDTH-1:0] wa, wr;
  logic [WIDTH:0] wx;
  logic run, run_n, last;
  logic [DIGIT:0] sum;
  logic [DIGIT-1:0] dig;
  logic [WIDTH+DIGIT-1:0] cat;
  generate
    if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
      $error("q2_serial_alu: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate
  assign busy = state == BUSY;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and per-digit datapath; wx carries flag_in above x so SHR's top bit rotates in naturally
  always_comb begin
    last = cnt == LAST;
    sum = {1'b0, wa[DIGIT-1:0]} + {1'b0, wx[DIGIT-1:0]} + {{DIGIT{1'b0}}, run};
    dig = wop == 2'b00 ? wx[DIGIT-1:0] :
          wop == 2'b01 ? ~(wa[DIGIT-1:0] | wx[DIGIT-1:0]) :
          wop == 2'b10 ? sum[DIGIT-1:0] : wx[DIGIT:1];
    run_n = wop[1] ? (wop[0] ? (cnt == '0 ? wx[0] : run) : sum[DIGIT]) : run & ~|dig;
    cat = {dig, wr};
    state_n = state == IDLE ? (start ? BUSY : IDLE) : (last ? IDLE : BUSY);
  end
  // working registers, counter and the architecturally visible result/flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      wop <= 2'b00;
      wa <= '0;
      wx <= '0;
      wr <= '0;
      run <= 1'b0;
      done <= 1'b0;
      result <= '0;
      flag_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        wa <= a;
        wx <= {flag_in, x};
        wop <= op;
        run <= flag_in;
        cnt <= '0;
      end else if (state == BUSY) begin
        wa <= wa >> DIGIT;
        wx <= wx >> DIGIT;
        wr <= cat[WIDTH+DIGIT-1:DIGIT];
        run <= run_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          result <= cat[WIDTH+DIGIT-1:DIGIT];
          flag_out <= run_n;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_q2_serial_alu.sv
// tb_q2_serial_alu: directed checks of the serial ALU at DIGIT=1 and DIGIT=4
module tb_q2_serial_alu;
  logic clk = 1'b0, rst = 1'b1;
  logic st1 = 1'b0, f1 = 1'b0, busy1, done1, fo1;
  logic [1:0] op1 = 2'b00;
  logic [15:0] a1 = '0, x1 = '0, res1;
  logic st4 = 1'b0, f4 = 1'b0, busy4, done4, fo4;
  logic [1:0] op4 = 2'b00;
  logic [15:0] a4 = '0, x4 = '0, res4;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  q2_serial_alu #(.WIDTH(16), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .start(st1), .op(op1), .a(a1), .x(x1),
    .flag_in(f1), .busy(busy1), .done(done1), .result(res1), .flag_out(fo1));
  q2_serial_alu #(.WIDTH(16), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .start(st4), .op(op4), .a(a4), .x(x4),
    .flag_in(f4), .busy(busy4), .done(done4), .result(res4), .flag_out(fo4));
  // lat = clock edges from the start-accepting edge to the edge that raised done
  task automatic go1(input logic now, input logic [1:0] o, input logic [15:0] av, xv, input logic fv, output int lat);
    if (!now) @(negedge clk);
    st1 = 1'b1; op1 = o; a1 = av; x1 = xv; f1 = fv; lat = -1;
    do begin @(negedge clk); st1 = 1'b0; lat++; end while (!done1 && lat < 40);
  endtask
  task automatic go4(input logic [1:0] o, input logic [15:0] av, xv, input logic fv, output int lat);
    @(negedge clk);
    st4 = 1'b1; op4 = o; a4 = av; x4 = xv; f4 = fv; lat = -1;
    do begin @(negedge clk); st4 = 1'b0; lat++; end while (!done4 && lat < 40);
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    vecs += 5;
    if (busy1 !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy1); end
    if (done1 !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done1); end
    if (res1 !== 16'h0) begin errs++; $display("FAIL reset_result got %h want 0000", res1); end
    if (fo1 !== 1'b0) begin errs++; $display("FAIL reset_flag got %b want 0", fo1); end
    if (busy4 !== 1'b0) begin errs++; $display("FAIL reset_busy4 got %b want 0", busy4); end
    rst = 1'b0;
  endtask
  task automatic test_add;
    int lat;
    go1(1'b0, 2'b10, 16'hFFFF, 16'h0001, 1'b0, lat);
    vecs += 3;
    if (lat !== 16) begin errs++; $display("FAIL add1_latency got %0d want 16", lat); end
    if (res1 !== 16'h0000) begin errs++; $display("FAIL add1_result got %h want 0000", res1); end
    if (fo1 !== 1'b1) begin errs++; $display("FAIL add1_carry got %b want 1", fo1); end
    go1(1'b0, 2'b10, 16'h1234, 16'h4321, 1'b1, lat);
    vecs += 2;
    if (res1 !== 16'h5556) begin errs++; $display("FAIL add2_result got %h want 5556", res1); end
    if (fo1 !== 1'b0) begin errs++; $display("FAIL add2_carry got %b want 0", fo1); end
  endtask
  task automatic test_nor_load;
    int lat;
    go1(1'b0, 2'b01, 16'hFF00, 16'h00FF, 1'b1, lat);
    vecs += 2;
    if (res1 !== 16'h0000) begin errs++; $display("FAIL nor_result got %h want 0000", res1); end
    if (fo1 !== 1'b1) begin errs++; $display("FAIL nor_flag got %b want 1", fo1); end
    go1(1'b0, 2'b00, 16'hAAAA, 16'h0100, 1'b1, lat);
    vecs += 2;
    if (res1 !== 16'h0100) begin errs++; $display("FAIL load_result got %h want 0100", res1); end
    if (fo1 !== 1'b0) begin errs++; $display("FAIL load_flag got %b want 0", fo1); end
    go1(1'b0, 2'b00, 16'hFFFF, 16'h0000, 1'b0, lat);
    vecs += 2;
    if (res1 !== 16'h0000) begin errs++; $display("FAIL load0_result got %h want 0000", res1); end
    if (fo1 !== 1'b0) begin errs++; $display("FAIL load0_flag got %b want 0", fo1); end
  endtask
  task automatic test_shr;
    int lat;
    go1(1'b0, 2'b11, 16'h0000, 16'h8001, 1'b0, lat);
    vecs += 2;
    if (res1 !== 16'h4000) begin errs++; $display("FAIL shr1_result got %h want 4000", res1); end
    if (fo1 !== 1'b1) begin errs++; $display("FAIL shr1_flag got %b want 1", fo1); end
    go1(1'b0, 2'b11, 16'hFFFF, 16'h0002, 1'b1, lat);
    vecs += 2;
    if (res1 !== 16'h8001) begin errs++; $display("FAIL shr2_result got %h want 8001", res1); end
    if (fo1 !== 1'b0) begin errs++; $display("FAIL shr2_flag got %b want 0", fo1); end
  endtask
  task automatic test_digit4;
    int lat;
    go4(2'b10, 16'h0FFF, 16'h0001, 1'b0, lat);
    vecs += 3;
    if (lat !== 4) begin errs++; $display("FAIL d4_add_latency got %0d want 4", lat); end
    if (res4 !== 16'h1000) begin errs++; $display("FAIL d4_add_result got %h want 1000", res4); end
    if (fo4 !== 1'b0) begin errs++; $display("FAIL d4_add_carry got %b want 0", fo4); end
    go4(2'b11, 16'h0000, 16'h0011, 1'b1, lat);
    vecs += 2;
    if (res4 !== 16'h8008) begin errs++; $display("FAIL d4_shr_result got %h want 8008", res4); end
    if (fo4 !== 1'b1) begin errs++; $display("FAIL d4_shr_flag got %b want 1", fo4); end
  endtask
  task automatic test_ignore_start;
    int lat = -1;
    logic [15:0] prev;
    prev = res1;
    @(negedge clk);
    st1 = 1'b1; op1 = 2'b10; a1 = 16'h0003; x1 = 16'h0004; f1 = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      st1 = lat == 2;
      if (lat == 2) begin op1 = 2'b00; x1 = 16'hFFFF; f1 = 1'b1; end
      if (lat == 8) begin
        vecs += 2;
        if (res1 !== prev) begin errs++; $display("FAIL busy_hold got %h want %h", res1, prev); end
        if (busy1 !== 1'b1) begin errs++; $display("FAIL busy_flag got %b want 1", busy1); end
      end
    end while (!done1 && lat < 40);
    vecs += 3;
    if (lat !== 16) begin errs++; $display("FAIL ignore_latency got %0d want 16", lat); end
    if (res1 !== 16'h0007) begin errs++; $display("FAIL ignore_result got %h want 0007", res1); end
    if (fo1 !== 1'b0) begin errs++; $display("FAIL ignore_flag got %b want 0", fo1); end
  endtask
  task automatic test_back_to_back;
    int lat;
    go1(1'b0, 2'b00, 16'h0000, 16'h00AA, 1'b0, lat);
    go1(1'b1, 2'b01, 16'h0000, 16'h00AA, 1'b1, lat);
    vecs += 3;
    if (lat !== 16) begin errs++; $display("FAIL b2b_latency got %0d want 16", lat); end
    if (res1 !== 16'hFF55) begin errs++; $display("FAIL b2b_result got %h want ff55", res1); end
    if (fo1 !== 1'b0) begin errs++; $display("FAIL b2b_flag got %b want 0", fo1); end
  endtask
  task automatic test_hold_start;
    int n = 0, first = -1, lastd = -1;
    @(negedge clk);
    st4 = 1'b1; op4 = 2'b10; a4 = 16'h0001; x4 = 16'h0001; f4 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (done4) begin n++; lastd = j; if (first < 0) first = j; end
    end
    st4 = 1'b0;
    repeat (6) @(negedge clk);
    vecs += 4;
    if (n !== 3) begin errs++; $display("FAIL hold_count got %0d want 3", n); end
    if (first !== 4) begin errs++; $display("FAIL hold_first got %0d want 4", first); end
    if (lastd !== 14) begin errs++; $display("FAIL hold_last got %0d want 14", lastd); end
    if (res4 !== 16'h0002) begin errs++; $display("FAIL hold_result got %h want 0002", res4); end
  endtask
  task automatic test_abort;
    int lat = -1, seen = 0;
    @(negedge clk);
    st1 = 1'b1; op1 = 2'b10; a1 = 16'hFFFF; x1 = 16'h0001; f1 = 1'b0;
    do begin @(negedge clk); st1 = 1'b0; lat++; end while (lat < 5);
    #2 rst = 1'b1;
    #1;
    vecs += 4;
    if (busy1 !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", busy1); end
    if (done1 !== 1'b0) begin errs++; $display("FAIL abort_done got %b want 0", done1); end
    if (res1 !== 16'h0) begin errs++; $display("FAIL abort_result got %h want 0000", res1); end
    if (fo1 !== 1'b0) begin errs++; $display("FAIL abort_flag got %b want 0", fo1); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin @(negedge clk); if (done1) seen++; end
    vecs += 2;
    if (seen !== 0) begin errs++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    if (busy1 !== 1'b0) begin errs++; $display("FAIL abort_idle got %b want 0", busy1); end
  endtask
  initial begin
    test_reset;
    test_add;
    test_nor_load;
    test_shr;
    test_digit4;
    test_ignore_start;
    test_back_to_back;
    test_hold_start;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
